// File: rtl/uart_rx_buffer_pkg.sv
// rtl/uart_rx_buffer_pkg.sv - shared CM item definitions: data width, receiver FSM states
// Parity build option: UART_RX_PARITY_EN adds the PARITY state.
package CM_item_pack;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_rx_state_t;

  // Even-parity bit for a data word: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [UART_DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_sync_fifo.sv
// rtl/uart_rx_buffer_sync_fifo.sv - first-word-fall-through FIFO with registered flags
// Head always shows mem[rd_ptr]; pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same clock, so a full FIFO can still accept a push.
  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | do_pop);
    count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count   <= count_next;
      empty   <= (count_next == '0);
      full    <= (count_next == (AW+1)'(DEPTH));
      overrun <= push & full & ~do_pop;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - oversampling UART receiver feeding a show-ahead receive FIFO
// Build option: UART_RX_PARITY_EN adds an even-parity bit and the Parity_Error output.
module uart_rx_buffer
  import CM_item_pack::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       RXD,
  input  logic                       Read,
  output logic [UART_DATA_WIDTH-1:0] RXD_Data,
  output logic                       Empty,
  output logic                       Full,
  output logic                       Overrun,
  output logic                       Frame_Error
`ifdef UART_RX_PARITY_EN
  ,
  output logic                       Parity_Error
`endif
);

  localparam int DIV   = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;

  logic                       rxd_meta;
  logic                       rxd_sync;
  logic                       rxd_prev;
  logic [DIV_W-1:0]           div_cnt;
  logic                       tick;
  logic [OS_W-1:0]            os_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic [UART_DATA_WIDTH-1:0] shift_q;
  uart_rx_state_t             state;
  uart_rx_state_t             state_next;
  logic                       fall;
  logic                       half_done;
  logic                       bit_done;
  logic                       last_bit;
  logic                       stop_sample;
  logic                       rx_push;
  logic                       frame_err_set;
`ifdef UART_RX_PARITY_EN
  logic                       parity_bad;
  logic                       parity_err_set;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Baud-tick divider runs free; bit timing is aligned by the per-bit tick counter instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    tick      = (div_cnt == DIV_W'(DIV - 1));
    fall      = rxd_prev & ~rxd_sync;
    half_done = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
    bit_done  = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
    last_bit  = (bit_cnt == BIT_W'(UART_DATA_WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fall) state_next = START;
      START:  if (half_done) state_next = rxd_sync ? IDLE : DATA;
      DATA: begin
        if (bit_done && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_done) state_next = STOP;
`endif
      STOP:   if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stop_sample   = (state == STOP) && bit_done;
    frame_err_set = stop_sample & ~rxd_sync;
`ifdef UART_RX_PARITY_EN
    parity_err_set = stop_sample & rxd_sync & parity_bad;
    rx_push        = stop_sample & rxd_sync & ~parity_bad;
`else
    rx_push        = stop_sample & rxd_sync;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      Frame_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      Parity_Error <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        os_cnt <= '0;
      end else if (bit_done || ((state == START) && half_done)) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_cnt + OS_W'(1);
      end

      if (state == START) begin
        bit_cnt <= '0;
      end else if ((state == DATA) && bit_done) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
        shift_q <= {rxd_sync, shift_q[UART_DATA_WIDTH-1:1]};
      end

      Frame_Error <= frame_err_set;
`ifdef UART_RX_PARITY_EN
      if ((state == PARITY) && bit_done) begin
        parity_bad <= even_parity(shift_q) ^ rxd_sync;
      end
      Parity_Error <= parity_err_set;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (shift_q),
    .pop       (Read),
    .head      (RXD_Data),
    .empty     (Empty),
    .full      (Full),
    .overrun   (Overrun)
  );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - directed scoreboard bench for uart_rx_buffer
module tb_uart_rx_buffer;
  import CM_item_pack::*;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int BAUD        = 1_562_500;
  localparam int OVERSAMPLE  = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int BIT_CLKS    = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RXD = 1'b1;
  logic       Read = 1'b0;
  logic [7:0] RXD_Data;
  logic       Empty;
  logic       Full;
  logic       Overrun;
  logic       Frame_Error;
`ifdef UART_RX_PARITY_EN
  logic       Parity_Error;
`endif

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_buffer #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .OVERSAMPLE  (OVERSAMPLE),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RXD         (RXD),
    .Read        (Read),
    .RXD_Data    (RXD_Data),
    .Empty       (Empty),
    .Full        (Full),
    .Overrun     (Overrun),
    .Frame_Error (Frame_Error)
`ifdef UART_RX_PARITY_EN
    ,
    .Parity_Error (Parity_Error)
`endif
  );

  always @(negedge clk) begin
    if (Frame_Error) fe_cnt++;
    if (Overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (Parity_Error) pe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    RXD = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(^d);
`endif
    bit_time(stop_v);
    RXD = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_push(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12 * BIT_CLKS && !ok; i++) begin
      @(negedge clk);
      if (dut.rx_push) ok = 1'b1;
    end
  endtask

  task automatic read_one(input string tag);
    logic [7:0] exp;
    check({tag, "_notempty"}, Empty, 1'b0);
    if (exp_q.size() == 0) begin
      check({tag, "_model_underflow"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, RXD_Data, exp);
    end
    Read = 1'b1;
    @(negedge clk);
    Read = 1'b0;
  endtask

  initial begin
    logic ok;
    int fe0;
    int ov0;
    int pe0;

    // reset state
    repeat (4) @(negedge clk);
    check("rst_empty", Empty, 1'b1);
    check("rst_full", Full, 1'b0);
    check("rst_data", RXD_Data, 8'h00);
    check("rst_overrun", Overrun, 1'b0);
    check("rst_frame_error", Frame_Error, 1'b0);
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);

    // 1: single frame, push timing, read
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_push(ok);
        check("t1_push_seen", ok, 1'b1);
        check("t1_empty_at_push", Empty, 1'b1);
        @(negedge clk);
        check("t1_empty_after_push", Empty, 1'b0);
        check("t1_head", RXD_Data, 8'hA5);
      end
    join
    read_one("t1");
    check("t1_empty_after_read", Empty, 1'b1);

    // 2: short low glitch is a false start
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    RXD = 1'b0;
    repeat (24) @(negedge clk);
    RXD = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("t2_empty", Empty, 1'b1);
    check("t2_no_frame_error", fe_cnt, fe0);
    check("t2_no_overrun", ov_cnt, ov0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    read_one("t2_after_glitch");
    check("t2_empty_after_read", Empty, 1'b1);

    // 3: bad stop bit
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    check("t3_frame_error_pulses", fe_cnt, fe0 + 1);
    check("t3_empty", Empty, 1'b1);

    // 4: fill to full then overrun
    ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1);
      if (i < FIFO_DEPTH) exp_q.push_back(8'(i));
      if (i == 14) check("t4_not_full_at_15", Full, 1'b0);
      if (i == 15) check("t4_full_at_16", Full, 1'b1);
    end
    check("t4_overrun_pulses", ov_cnt, ov0 + 1);
    check("t4_full_after_17", Full, 1'b1);
    for (int i = 0; i < FIFO_DEPTH; i++) read_one("t4_read");
    check("t4_empty_after_reads", Empty, 1'b1);
    check("t4_full_after_reads", Full, 1'b0);

    // 5: push and read on the same clock while full
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      send_frame(8'h60 + 8'(i), 1'b1);
      exp_q.push_back(8'h60 + 8'(i));
    end
    check("t5_full_before", Full, 1'b1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        wait_push(ok);
        check("t5_push_seen", ok, 1'b1);
        check("t5_head_at_push", RXD_Data, exp_q[0]);
        Read = 1'b1;
        @(negedge clk);
        Read = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        check("t5_full_after", Full, 1'b1);
      end
    join
    check("t5_no_overrun", ov_cnt, ov0);
    for (int i = 0; i < FIFO_DEPTH; i++) read_one("t5_read");
    check("t5_empty_after_reads", Empty, 1'b1);

    // 6: reset mid-frame with bytes queued
    for (int i = 1; i <= 3; i++) begin
      send_frame(8'h11 * 8'(i), 1'b1);
      exp_q.push_back(8'h11 * 8'(i));
    end
    check("t6_queued_notempty", Empty, 1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_empty", Empty, 1'b1);
    check("t6_rst_full", Full, 1'b0);
    check("t6_rst_data", RXD_Data, 8'h00);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    RXD = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    read_one("t6_after_reset");
    check("t6_empty_after_read", Empty, 1'b1);

`ifdef UART_RX_PARITY_EN
    // parity mismatch: 0x01 needs parity bit 1
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(i == 0);
    bit_time(1'b0);
    bit_time(1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("tp_parity_error_pulses", pe_cnt, pe0 + 1);
    check("tp_no_frame_error", fe_cnt, fe0);
    check("tp_empty", Empty, 1'b1);
`else
    pe0 = pe_cnt;
    check("tp_no_parity_counts", pe_cnt, pe0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
